// File: rtl/lc3_pkg.sv
// ---------------------------------------------------------------------------
// | lc3_pkg : shared LC3 memory-stage types and Writeback select codes      |
// | Rev 1.0                                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

package lc3_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LD   = 3'd1,
    OP_LDI  = 3'd2,
    OP_ST   = 3'd3,
    OP_STI  = 3'd4
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IND  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } mem_state_e;

  localparam logic [1:0] c_w_ctrl_alu = 2'd0;
  localparam logic [1:0] c_w_ctrl_mem = 2'd1;
  localparam logic [1:0] c_w_ctrl_pc  = 2'd2;

  // Raw codes 5-7 are reserved and behave as NONE.
  function automatic mem_op_e decode_op(input logic [2:0] raw);
    mem_op_e op;
    op = OP_NONE;
    case (raw)
      3'd1:    op = OP_LD;
      3'd2:    op = OP_LDI;
      3'd3:    op = OP_ST;
      3'd4:    op = OP_STI;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// | mem_access : LC3 memory stage running LD/LDI/ST/STI over req/ack        |
// | Rev 1.0                                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access
  import lc3_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] M_Addr,
  input  logic [DATA_W-1:0] M_Data,
  input  logic [DATA_W-1:0] Data_dout,
  input  logic              Data_ack,
  output logic              Data_req,
  output logic              Data_we,
  output logic [ADDR_W-1:0] Data_addr,
  output logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] memout,
  output logic              busy,
  output logic              mem_valid,
  output logic              mem_err
);

  localparam int c_cnt_w = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(MAX_WAIT - 1);

  mem_state_e          state_q,  state_d;
  mem_op_e             op_q,     op_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [DATA_W-1:0]   data_q,   data_d;
  logic [ADDR_W-1:0]   ptr_q,    ptr_d;
  logic [DATA_W-1:0]   memout_q, memout_d;
  logic [c_cnt_w-1:0]  wait_q,   wait_d;
  logic                gap_q,    gap_d;
  logic                err_q,    err_d;

  logic w_req;
  logic w_store;
  logic w_indirect;
  logic w_write;
  logic w_timeout;

  // gap_q holds Data_req low for one ACC cycle after the pointer read.
  assign w_req      = (state_q == S_IND) || ((state_q == S_ACC) && !gap_q);
  assign w_store    = (op_q == OP_ST)  || (op_q == OP_STI);
  assign w_indirect = (op_q == OP_LDI) || (op_q == OP_STI);
  assign w_write    = w_req && (state_q == S_ACC) && w_store;
  assign w_timeout  = (wait_q == c_wait_last);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ptr_d    = ptr_q;
    memout_d = memout_q;
    wait_d   = wait_q;
    gap_d    = gap_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = decode_op(mem_op);
          addr_d = M_Addr;
          data_d = M_Data;
          wait_d = '0;
          gap_d  = 1'b0;
          err_d  = 1'b0;
          case (decode_op(mem_op))
            OP_LD, OP_ST:   state_d = S_ACC;
            OP_LDI, OP_STI: state_d = S_IND;
            default:        state_d = S_DONE;
          endcase
        end
      end
      S_IND: begin
        if (Data_ack) begin
          ptr_d   = ADDR_W'(Data_dout);
          wait_d  = '0;
          gap_d   = 1'b1;
          state_d = S_ACC;
        end else if (w_timeout) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + c_cnt_w'(1);
        end
      end
      S_ACC: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (Data_ack) begin
          if (!w_store) memout_d = Data_dout;
          state_d = S_DONE;
        end else if (w_timeout) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + c_cnt_w'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NONE;
      addr_q   <= '0;
      data_q   <= '0;
      ptr_q    <= '0;
      memout_q <= '0;
      wait_q   <= '0;
      gap_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ptr_q    <= ptr_d;
      memout_q <= memout_d;
      wait_q   <= wait_d;
      gap_q    <= gap_d;
      err_q    <= err_d;
    end
  end

  assign Data_req  = w_req;
  assign Data_we   = w_write;
  assign Data_addr = !w_req ? '0 : ((state_q == S_ACC) && w_indirect) ? ptr_q : addr_q;
  assign Data_din  = w_write ? data_q : '0;
  assign memout    = memout_q;
  assign busy      = (state_q != S_IDLE);
  assign mem_valid = (state_q == S_DONE);
  assign mem_err   = (state_q == S_DONE) && err_q;

endmodule

`default_nettype wire
